rtc_line_builder: RTL and testbench
===================================

Name: rtc_line_builder

Overview:
- Upstream feeder of the 2x16 LCD controller: keeps wall-clock time (HH:MM:SS, BCD) plus a day counter.
- Formats them into two registered 16-character ASCII lines, LineA and LineB, for the controller's line inputs.
- Column c of a line occupies bits [c*8+:8]; column 0 is the leftmost character.
- Provides a set-time handshake, a run/hold control, and a one-second tick output.

Parameters:
- CYC_PER_SEC, 1000, mclk cycles per second tick; must be >= 2.
- DAY_MAX, 999, last day count before wrap to 0; must be <= 999.

Ports:
- mclk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  1 = time advances; 0 = hold (prescaler frozen)
- set_valid  in  1  set request; accepted when set_valid && set_ready
- set_hh  in  8  BCD hours 00-23
- set_mm  in  8  BCD minutes 00-59
- set_ss  in  8  BCD seconds 00-59
- set_ready  out  1  can accept a set request
- set_err  out  1  one-cycle pulse: accepted request had an invalid field
- sec_tick  out  1  one-cycle pulse when the time advances one second
- LineA  out  128  ASCII line 1
- LineB  out  128  ASCII line 2
- line_upd  out  1  one-cycle pulse in the first cycle new LineA/LineB values are visible

Behaviour:
- Reset:
  - time 00:00:00, day 0, prescaler 0, set_ready 1, set_err 0, sec_tick 0, line_upd 0.
  - LineA = "TIME  00:00:00  ", LineB = "DAY 000 RUN     ". Lines carry formatted reset values, never zeros.
- Prescaler:
  - Counts 0..CYC_PER_SEC-1 while run=1.
  - On the terminal count it wraps to 0 and the time increments in the same edge; sec_tick is high in the following cycle.
  - run=0 holds the prescaler value; no ticks occur.
- Increment (BCD digit-wise, no binary conversion):
  - ss 59->00 carries into mm.
  - mm 59->00 carries into hh.
  - hh 23->00 carries into day.
  - day DAY_MAX->0.
- Formatting, registered, one cycle after the counter change:
  - LineA: cols 0-3 "TIME", 4-5 space, 6-7 HH, 8 ':', 9-10 MM, 11 ':', 12-13 SS, 14-15 space.
  - LineB: cols 0-3 "DAY ", 4-6 day as 3 BCD digits, 7 space, 8-11 "RUN " when run=1 else "HOLD", 12-15 space.
  - Digit character = 8'h30 + nibble.
  - line_upd pulses in the same cycle the new values appear.
  - Any change of run also rebuilds the lines and pulses line_upd.
  - If a tick and a run change coincide, a single rebuild with a single line_upd covers both.
- Set handshake:
  - Accept on a rising mclk edge with set_valid && set_ready.
  - The next cycle set_ready=0, one busy cycle; it returns to 1 the cycle after.
  - Valid request (every nibble <= 9, hh <= 23, mm <= 59, ss <= 59):
    - time loads and the prescaler clears to 0.
    - The day is unchanged.
    - The lines rebuild and line_upd pulses 1 cycle after acceptance.
  - Invalid request: time unchanged, set_err pulses 1 cycle after acceptance, no line_upd.
  - set_valid while set_ready=0 is ignored, not queued.
- Simultaneous events:
  - Accepted set on a terminal-count cycle: the set wins, no increment, no sec_tick.
  - Invalid set on a terminal-count cycle: the tick proceeds normally.
- Reset mid-operation: all state returns to reset values on the next edge, including a pending busy cycle and pending pulses.

Optional Feature:
- Macro: RTC_LINE_HOUR12_EN.
- Defined:
  - LineA shows 12-hour time: hh 00 -> "12", 13-23 -> 01-11.
  - cols 14-15 show "AM" for internal hh 00-11 and "PM" for 12-23.
  - Reset LineA = "TIME  12:00:00AM".
- Not defined: 24-hour display, cols 14-15 spaces.
- In both cases the internal counters, set inputs and validation stay 24-hour.

Test Plan:
- Reset release with CYC_PER_SEC=4, run=1:
  - Required: LineA="TIME  00:00:00  ", LineB="DAY 000 RUN     ".
  - Required: first sec_tick at cycle 4 after reset, then every 4 cycles.
  - Required: after the 1st tick, LineA shows 00:00:01 with line_upd.
- Set 23:59:58 (hh=8'h23, mm=8'h59, ss=8'h58), day=DAY_MAX via ticks (DAY_MAX=2):
  - Required: 2 ticks -> 00:00:00.
  - Required: day wraps to 000 and LineB cols 4-6 read "000".
- Invalid set mm=8'h60, and separately ss=8'h0A:
  - Required: set_err pulse 1 cycle after accept.
  - Required: time and lines unchanged, no line_upd.
  - Required: set_ready low exactly 1 cycle.
- run=0 for 20 cycles:
  - Required: no sec_tick, LineB cols 8-11 "HOLD" with a line_upd.
  - Required: on run=1 the prescaler resumes from the held value, "RUN " is restored, and the next tick arrives after the remaining count.
- Valid set asserted on the terminal-count cycle:
  - Required: the set value appears, no increment, no sec_tick that cycle.
  - Required: the next tick arrives CYC_PER_SEC cycles after acceptance.
- RTC_LINE_HOUR12_EN defined, set 12:30:00 then 00:05:00:
  - Required: LineA "TIME  12:30:00PM" then "TIME  12:05:00AM".
  - Required: rst mid-busy restores "TIME  12:00:00AM".

Source files
------------

// File: rtl/rtc_line_builder.sv
// rtl/rtc_line_builder.sv - BCD wall clock + day counter formatted into two 16-char ASCII LCD lines
// Optional 12-hour display on LineA when RTC_LINE_HOUR12_EN is defined.
module rtc_line_builder #(
  parameter int CYC_PER_SEC = 1000,
  parameter int DAY_MAX     = 999
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         run,
  input  logic         set_valid,
  input  logic [7:0]   set_hh,
  input  logic [7:0]   set_mm,
  input  logic [7:0]   set_ss,
  output logic         set_ready,
  output logic         set_err,
  output logic         sec_tick,
  output logic [127:0] LineA,
  output logic [127:0] LineB,
  output logic         line_upd
);

  localparam int            PW         = $clog2(CYC_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_SEC - 1);
  localparam logic [11:0]   DAY_LAST   = {4'(DAY_MAX / 100), 4'((DAY_MAX / 10) % 10), 4'(DAY_MAX % 10)};

  logic [PW-1:0] presc;
  logic [7:0]    hh, mm, ss;
  logic [11:0]   day;
  logic          busy;
  logic          run_q;
  logic          upd_req;
  logic          err_req;

  logic accept, set_ok, load, tick;
  logic ss_wrap, mm_wrap, hh_wrap;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [7:0] inc_bcd2(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [11:0] inc_bcd3(input logic [11:0] v);
    if (v[3:0] != 4'd9)
      return {v[11:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd9)
      return {v[11:8], v[7:4] + 4'd1, 4'd0};
    else
      return {v[11:8] + 4'd1, 8'h00};
  endfunction

  function automatic logic [7:0] dig(input logic [3:0] n);
    return {4'h3, n};
  endfunction

`ifdef RTC_LINE_HOUR12_EN
  function automatic logic [7:0] hour12(input logic [7:0] h);
    case (h)
      8'h00:   return 8'h12;
      8'h13:   return 8'h01;
      8'h14:   return 8'h02;
      8'h15:   return 8'h03;
      8'h16:   return 8'h04;
      8'h17:   return 8'h05;
      8'h18:   return 8'h06;
      8'h19:   return 8'h07;
      8'h20:   return 8'h08;
      8'h21:   return 8'h09;
      8'h22:   return 8'h10;
      8'h23:   return 8'h11;
      default: return h;
    endcase
  endfunction
`endif

  function automatic logic [127:0] fmt_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    logic [127:0] line;
    logic [7:0]   dh;
    line = {16{8'h20}};
`ifdef RTC_LINE_HOUR12_EN
    dh = hour12(h);
    line[119:112] = (h < 8'h12) ? "A" : "P";
    line[127:120] = "M";
`else
    dh = h;
`endif
    line[7:0]     = "T";
    line[15:8]    = "I";
    line[23:16]   = "M";
    line[31:24]   = "E";
    line[55:48]   = dig(dh[7:4]);
    line[63:56]   = dig(dh[3:0]);
    line[71:64]   = ":";
    line[79:72]   = dig(m[7:4]);
    line[87:80]   = dig(m[3:0]);
    line[95:88]   = ":";
    line[103:96]  = dig(s[7:4]);
    line[111:104] = dig(s[3:0]);
    return line;
  endfunction

  function automatic logic [127:0] fmt_b(input logic [11:0] d, input logic r);
    logic [127:0] line;
    line = {16{8'h20}};
    line[7:0]   = "D";
    line[15:8]  = "A";
    line[23:16] = "Y";
    line[39:32] = dig(d[11:8]);
    line[47:40] = dig(d[7:4]);
    line[55:48] = dig(d[3:0]);
    line[71:64] = r ? "R" : "H";
    line[79:72] = r ? "U" : "O";
    line[87:80] = r ? "N" : "L";
    line[95:88] = r ? " " : "D";
    return line;
  endfunction

  assign set_ready = !busy;
  assign accept    = set_valid && !busy;
  assign set_ok    = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
  assign load      = accept && set_ok;
  // A loading set owns the edge: the terminal count is swallowed rather than ticking.
  assign tick      = run && (presc == PRESC_LAST) && !load;
  assign ss_wrap   = (ss == 8'h59);
  assign mm_wrap   = (mm == 8'h59);
  assign hh_wrap   = (hh == 8'h23);

  always_ff @(posedge mclk) begin
    if (rst) begin
      presc    <= '0;
      hh       <= 8'h00;
      mm       <= 8'h00;
      ss       <= 8'h00;
      day      <= 12'h000;
      busy     <= 1'b0;
      run_q    <= 1'b1;
      upd_req  <= 1'b0;
      err_req  <= 1'b0;
      set_err  <= 1'b0;
      sec_tick <= 1'b0;
      line_upd <= 1'b0;
      LineA    <= fmt_a(8'h00, 8'h00, 8'h00);
      LineB    <= fmt_b(12'h000, 1'b1);
    end else begin
      busy     <= accept;
      run_q    <= run;
      sec_tick <= tick;
      // Every cause of a rebuild funnels through one request bit, so coincident causes share one line_upd.
      upd_req  <= load || tick || (run != run_q);
      err_req  <= accept && !set_ok;
      set_err  <= err_req;
      line_upd <= upd_req;
      if (upd_req) begin
        LineA <= fmt_a(hh, mm, ss);
        LineB <= fmt_b(day, run_q);
      end
      if (load) begin
        hh    <= set_hh;
        mm    <= set_mm;
        ss    <= set_ss;
        presc <= '0;
      end else if (run) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          ss    <= ss_wrap ? 8'h00 : inc_bcd2(ss);
          if (ss_wrap) begin
            mm <= mm_wrap ? 8'h00 : inc_bcd2(mm);
            if (mm_wrap) begin
              hh <= hh_wrap ? 8'h00 : inc_bcd2(hh);
              if (hh_wrap)
                day <= (day == DAY_LAST) ? 12'h000 : inc_bcd3(day);
            end
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_line_builder.sv
// tb/tb_rtc_line_builder.sv - scoreboard bench for rtc_line_builder against an integer-seconds time model
module tb_rtc_line_builder;

  localparam int CYC  = 4;
  localparam int DMAX = 2;

  logic         mclk = 1'b0;
  logic         rst, run, set_valid;
  logic [7:0]   set_hh, set_mm, set_ss;
  logic         set_ready, set_err, sec_tick, line_upd;
  logic [127:0] LineA, LineB;

  rtc_line_builder #(.CYC_PER_SEC(CYC), .DAY_MAX(DMAX)) dut (
    .mclk(mclk), .rst(rst), .run(run), .set_valid(set_valid),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_ready(set_ready), .set_err(set_err), .sec_tick(sec_tick),
    .LineA(LineA), .LineB(LineB), .line_upd(line_upd)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int           cyc;
    logic [127:0] a;
    logic [127:0] b;
    bit           upd;
  } line_ev_t;

  line_ev_t     q_line[$];
  int           q_tick[$];
  int           q_err[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  bit           mon_en = 0;
  logic [127:0] cur_a, cur_b;

  // model state: time of day as plain seconds
  int m_presc, m_secs, m_day;
  bit m_busy, m_prev_run;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] to_vec(input string s);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) v[c*8 +: 8] = s[c];
    return v;
  endfunction

  function automatic logic [127:0] exp_a(input int secs);
    int h, m, s;
    string str;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
`ifdef RTC_LINE_HOUR12_EN
    begin
      string sfx;
      int    h12;
      h12 = (h % 12 == 0) ? 12 : h % 12;
      sfx = (h < 12) ? "AM" : "PM";
      str = $sformatf("TIME  %02d:%02d:%02d%s", h12, m, s, sfx);
    end
`else
    str = $sformatf("TIME  %02d:%02d:%02d  ", h, m, s);
`endif
    return to_vec(str);
  endfunction

  function automatic logic [127:0] exp_b(input int d, input bit r);
    string mode;
    mode = r ? "RUN " : "HOLD";
    return to_vec($sformatf("DAY %03d %s    ", d, mode));
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int max);
    return (b[7:4] <= 9) && (b[3:0] <= 9) && (int'(b[7:4]) * 10 + int'(b[3:0]) <= max);
  endfunction

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic void model_reset();
    while (q_line.size() > 0 && q_line[$].cyc > cyc) void'(q_line.pop_back());
    while (q_tick.size() > 0 && q_tick[$] > cyc) void'(q_tick.pop_back());
    while (q_err.size() > 0 && q_err[$] > cyc) void'(q_err.pop_back());
    m_presc = 0; m_secs = 0; m_day = 0; m_busy = 0; m_prev_run = 1;
    q_line.push_back('{cyc + 1, exp_a(0), exp_b(0, 1'b1), 1'b0});
  endfunction

  // Predicts the effect of the coming clock edge from the inputs about to be driven.
  function automatic void model_edge(input bit rv, input bit sv, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    int nxt;
    bit acc, ok, tk;
    nxt = cyc + 1;
    acc = sv && !m_busy;
    ok  = field_ok(h, 23) && field_ok(m, 59) && field_ok(s, 59);
    tk  = 0;
    if (acc && ok) begin
      m_secs  = bcd2i(h) * 3600 + bcd2i(m) * 60 + bcd2i(s);
      m_presc = 0;
    end else if (rv) begin
      if (m_presc == CYC - 1) begin
        m_presc = 0;
        tk = 1;
        m_secs++;
        if (m_secs == 86400) begin
          m_secs = 0;
          m_day  = (m_day == DMAX) ? 0 : m_day + 1;
        end
      end else begin
        m_presc++;
      end
    end
    if (tk) q_tick.push_back(nxt);
    if (acc && !ok) q_err.push_back(nxt + 1);
    if ((acc && ok) || tk || (rv != m_prev_run))
      q_line.push_back('{nxt + 1, exp_a(m_secs), exp_b(m_day, rv), 1'b1});
    m_prev_run = rv;
    m_busy     = acc;
  endfunction

  task automatic step(input bit r, input bit rv, input bit sv, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if (mon_en) chk(set_ready === !m_busy, "set_ready", 128'(set_ready), 128'(!m_busy));
    rst = r; run = rv; set_valid = sv; set_hh = h; set_mm = m; set_ss = s;
    if (r) model_reset();
    else model_edge(rv, sv, h, m, s);
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n, input bit rv);
    for (int i = 0; i < n; i++) step(1'b0, rv, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  always @(negedge mclk) begin
    if (mon_en) begin
      bit exp_t, exp_e, exp_u;
      exp_t = (q_tick.size() > 0 && q_tick[0] == cyc);
      if (exp_t) void'(q_tick.pop_front());
      chk(sec_tick === exp_t, "sec_tick", 128'(sec_tick), 128'(exp_t));
      exp_e = (q_err.size() > 0 && q_err[0] == cyc);
      if (exp_e) void'(q_err.pop_front());
      chk(set_err === exp_e, "set_err", 128'(set_err), 128'(exp_e));
      exp_u = 0;
      if (q_line.size() > 0 && q_line[0].cyc == cyc) begin
        line_ev_t ev;
        ev    = q_line.pop_front();
        exp_u = ev.upd;
        cur_a = ev.a;
        cur_b = ev.b;
      end
      chk(line_upd === exp_u, "line_upd", 128'(line_upd), 128'(exp_u));
      chk(LineA === cur_a, "LineA", LineA, cur_a);
      chk(LineB === cur_b, "LineB", LineB, cur_b);
    end
  end

  initial begin
    bit rr;
    rr = 1;
    rst = 1; run = 1; set_valid = 0; set_hh = 0; set_mm = 0; set_ss = 0;
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    mon_en = 1;
    idle(14, 1'b1);

    // midnight rollover three times walks the day counter through its wrap
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h58);
      idle(12, 1'b1);
    end

    // invalid sets; the second request lands on the busy cycle and is dropped
    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h60, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h60, 8'h00);
    idle(5, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h10, 8'h20, 8'h0A);
    idle(5, 1'b1);

    idle(20, 1'b0);
    idle(10, 1'b1);

    // valid set on the terminal-count edge
    for (int i = 0; i < 2 * CYC && m_presc != CYC - 1; i++) idle(1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h07, 8'h41, 8'h19);
    idle(8, 1'b1);

    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h30, 8'h00);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 8'h00);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h15, 8'h45, 8'h30);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(6, 1'b1);

    for (int i = 0; i < 700; i++) begin
      bit r, sv;
      logic [7:0] h, m, s;
      if ($urandom_range(0, 15) == 0) rr = !rr;
      r  = ($urandom_range(0, 199) == 0);
      sv = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) < 6) begin
        h = i2bcd($urandom_range(0, 23));
        m = i2bcd($urandom_range(0, 59));
        s = (($urandom_range(0, 3) == 0) ? 8'h59 : i2bcd($urandom_range(0, 59)));
      end else begin
        h = 8'($urandom);
        m = 8'($urandom);
        s = 8'($urandom);
      end
      step(r, rr, sv, h, m, s);
    end
    idle(10, 1'b1);

    chk(q_line.size() == 0, "line_queue_drained", 128'(q_line.size()), 128'(0));
    chk(q_tick.size() == 0, "tick_queue_drained", 128'(q_tick.size()), 128'(0));
    chk(q_err.size() == 0, "err_queue_drained", 128'(q_err.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
